pci_target_ctrl: RTL and testbench

PCI target-side transaction controller, directly upstream of the read/write-enable decode stage.
- Detects the address phase, decodes command and address against a fixed memory window, and claims the cycle with devsel_n.
- Paces data phases with trdy_n, handles disconnect with stop_n, and tracks the burst word address.
- Produces the 2-bit rw code and the active-low devsel_n consumed by the enable-decode stage.

---
 rtl/pci_tgt_pkg.sv | 19 +
 rtl/pci_addr_decode.sv | 24 ++
 rtl/pci_target_ctrl.sv | 141 ++++++++++++++
 tb/tb_pci_target_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pci_tgt_pkg.sv
// Shared command codes, rw encodings and FSM state type for the PCI target controller.
package pci_tgt_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [1:0] RW_NONE  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DATA,
        ST_DISC,
        ST_TURN
    } state_t;

endpackage

// File: rtl/pci_addr_decode.sv
// Combinational address-window and command decode for the PCI target address phase.
module pci_addr_decode
    import pci_tgt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic [31:0] ad,
    input  logic [3:0]  cbe_n,
    output logic        hit,
    output logic        is_rd,
    output logic        is_wr
);

    // Compare only the bits above the window offset; the low bits are masked off.
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    always_comb begin
        hit   = (((ad ^ BASE_ADDR) & WIN_MASK) == '0);
        is_rd = (cbe_n == CMD_MEM_RD);
        is_wr = (cbe_n == CMD_MEM_WR);
    end

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI target transaction controller: claims window hits, paces data phases, disconnects at window end.
// Optional macro PCI_TGT_WAIT_STATE_EN inserts one trdy_n wait cycle after each non-final transfer.
module pci_target_ctrl
    import pci_tgt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_n,
    input  logic              irdy_n,
    input  logic [31:0]       ad,
    input  logic [3:0]        cbe_n,
    output logic              devsel_n,
    output logic              trdy_n,
    output logic              stop_n,
    output logic [1:0]        rw,
    output logic [ADDR_W-1:0] word_addr,
    output logic              xfer
);

`ifdef PCI_TGT_WAIT_STATE_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] WA_MAX = '1;

    state_t            state_q, state_d;
    logic              frame_q;
    logic              devsel_q, devsel_d;
    logic              trdy_q, trdy_d;
    logic              stop_q, stop_d;
    logic [1:0]        rw_q, rw_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic              hit, is_rd, is_wr;
    logic              addr_phase;
    logic              to_turn;

    pci_addr_decode #(
        .BASE_ADDR(BASE_ADDR),
        .ADDR_W   (ADDR_W)
    ) u_decode (
        .ad   (ad),
        .cbe_n(cbe_n),
        .hit  (hit),
        .is_rd(is_rd),
        .is_wr(is_wr)
    );

    assign addr_phase = !frame_n && frame_q;
    assign xfer       = (state_q == ST_DATA) && !irdy_n && !trdy_q;

    always_comb begin
        state_d  = state_q;
        devsel_d = devsel_q;
        trdy_d   = trdy_q;
        stop_d   = stop_q;
        rw_d     = rw_q;
        wa_d     = wa_q;
        to_turn  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_phase) begin
                    if (hit && (is_rd || is_wr)) begin
                        state_d  = ST_DATA;
                        wa_d     = ad[ADDR_W+1:2];
                        rw_d     = is_wr ? RW_WRITE : RW_READ;
                        devsel_d = 1'b0;
                        // Reads hold trdy_n one extra cycle for AD turnaround.
                        trdy_d   = !is_wr;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (frame_n && irdy_n) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (xfer) begin
                    if (wa_q != WA_MAX) wa_d = wa_q + 1'b1;
                    if (frame_n) begin
                        to_turn = 1'b1;
                    end else if (wa_q == WA_MAX) begin
                        state_d = ST_DISC;
                        stop_d  = 1'b0;
                        trdy_d  = 1'b1;
                    end else begin
                        trdy_d = WAIT_EN;
                    end
                end else if (frame_n && irdy_n) begin
                    to_turn = 1'b1;
                end else begin
                    trdy_d = 1'b0;
                end
            end
            ST_DISC: begin
                if (frame_n) to_turn = 1'b1;
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (to_turn) begin
            state_d  = ST_TURN;
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            stop_d   = 1'b1;
            rw_d     = RW_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            frame_q  <= 1'b1;
            devsel_q <= 1'b1;
            trdy_q   <= 1'b1;
            stop_q   <= 1'b1;
            rw_q     <= RW_NONE;
            wa_q     <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_n;
            devsel_q <= devsel_d;
            trdy_q   <= trdy_d;
            stop_q   <= stop_d;
            rw_q     <= rw_d;
            wa_q     <= wa_d;
        end
    end

    assign devsel_n  = devsel_q;
    assign trdy_n    = trdy_q;
    assign stop_n    = stop_q;
    assign rw        = rw_q;
    assign word_addr = wa_q;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Scoreboard bench for pci_target_ctrl: each cycle's expected outputs are queued with the stimulus.
module tb_pci_target_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_n = 1'b1;
    logic        irdy_n = 1'b1;
    logic [31:0] ad = '0;
    logic [3:0]  cbe_n = 4'hF;
    logic        devsel_n, trdy_n, stop_n, xfer;
    logic [1:0]  rw;
    logic [3:0]  word_addr;

    typedef struct {
        int          idx;
        logic        devsel, trdy, stop, xfer;
        logic [1:0]  rw;
        logic [3:0]  wa;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    pci_target_ctrl #(
        .BASE_ADDR(32'h0000_1000),
        .ADDR_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .ad       (ad),
        .cbe_n    (cbe_n),
        .devsel_n (devsel_n),
        .trdy_n   (trdy_n),
        .stop_n   (stop_n),
        .rw       (rw),
        .word_addr(word_addr),
        .xfer     (xfer)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Inputs are driven on the falling edge; expected values describe that cycle's outputs.
    task automatic step(input logic r, input logic f, input logic i, input logic [31:0] a,
                        input logic [3:0] c, input logic chk, input logic dv, input logic tr,
                        input logic sp, input logic [1:0] rwe, input logic [3:0] wa,
                        input logic xf);
        exp_t e;
        @(negedge clk);
        rst = r; frame_n = f; irdy_n = i; ad = a; cbe_n = c;
        step_no++;
        if (chk) begin
            e.idx = step_no; e.devsel = dv; e.trdy = tr; e.stop = sp;
            e.rw = rwe; e.wa = wa; e.xfer = xf;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("s%0d devsel_n", e.idx), 32'(devsel_n), 32'(e.devsel));
            check_eq($sformatf("s%0d trdy_n", e.idx), 32'(trdy_n), 32'(e.trdy));
            check_eq($sformatf("s%0d stop_n", e.idx), 32'(stop_n), 32'(e.stop));
            check_eq($sformatf("s%0d rw", e.idx), 32'(rw), 32'(e.rw));
            check_eq($sformatf("s%0d word_addr", e.idx), 32'(word_addr), 32'(e.wa));
            check_eq($sformatf("s%0d xfer", e.idx), 32'(xfer), 32'(e.xfer));
        end
    end

    localparam logic [3:0] RD = 4'b0110, WR = 4'b0111;

    initial begin
        // reset
        step(1, 1, 1, 0, 4'hF, 0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 0, 0);
        // single write at dword 2
        step(0, 0, 1, 32'h0000_1008, WR, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 2, 2, 1);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        // read burst of 3 from dword 0
        step(0, 0, 1, 32'h0000_1000, RD, 1, 1, 1, 1, 0, 3, 0);
        step(0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 1, 0, 0);
`ifdef PCI_TGT_WAIT_STATE_EN
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 1, 2, 0);
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 1, 2, 1);
`else
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 1, 2, 1);
`endif
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        // address miss, then a hit attempt while still BUSY must be ignored
        step(0, 0, 1, 32'h0000_2000, WR, 1, 1, 1, 1, 0, 3, 0);
        step(0, 0, 0, 0, 4'h0, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 0, 0, 4'h0, 1, 1, 1, 1, 0, 3, 0);
        step(0, 0, 1, 32'h0000_1000, WR, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        // unsupported command inside the window
        step(0, 0, 1, 32'h0000_1000, 4'b0010, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 3, 0);
        // window end: write at dword 15 with frame held, then disconnect
        step(0, 0, 1, 32'h0000_103C, WR, 1, 1, 1, 1, 0, 3, 0);
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 15, 1);
        step(0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 2, 15, 0);
        step(0, 1, 0, 0, 4'h0, 1, 0, 1, 0, 2, 15, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 15, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 15, 0);
        // master wait states, then reset mid-burst
        step(0, 0, 1, 32'h0000_1010, WR, 1, 1, 1, 1, 0, 15, 0);
        step(0, 0, 1, 0, 4'h0, 1, 0, 0, 1, 2, 4, 0);
        step(0, 0, 1, 0, 4'h0, 1, 0, 0, 1, 2, 4, 0);
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 4, 1);
`ifdef PCI_TGT_WAIT_STATE_EN
        step(0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 2, 5, 0);
        step(1, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 5, 1);
`else
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 5, 1);
        step(1, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 6, 1);
`endif
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 0, 0);
        // post-reset single write proves the FSM is back in IDLE
        step(0, 0, 1, 32'h0000_1004, WR, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 2, 1, 1);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 2, 0);
        // write burst of 2 from dword 0
        step(0, 0, 1, 32'h0000_1000, WR, 1, 1, 1, 1, 0, 2, 0);
        step(0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 2, 0, 1);
`ifdef PCI_TGT_WAIT_STATE_EN
        step(0, 1, 0, 0, 4'h0, 1, 0, 1, 1, 2, 1, 0);
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 2, 1, 1);
`else
        step(0, 1, 0, 0, 4'h0, 1, 0, 0, 1, 2, 1, 1);
`endif
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 2, 0);
        step(0, 1, 1, 0, 4'hF, 1, 1, 1, 1, 0, 2, 0);
        @(negedge clk);
        #4;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
